dmem_store_buffer: RTL and testbench
====================================

# dmem_store_buffer

Store buffer between the single-cycle core's data-memory store port (`mem_write`, `data_adr`, `write_data`) and a data memory with a valid/ready write port. Accepts one store per cycle into a circular FIFO, drains it in order to memory, stalls the core when full, and forwards the youngest matching buffered word to core loads so read-after-write stays correct while stores are in flight.

## Interface
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `AW`, default 32: address width.
- `DW`, default 32: data width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous reset, **active-low**; 0 clears all state immediately.
- `mem_write`  in  1  core store request, one cycle per store.
- `data_adr`  in  AW  store byte address.
- `write_data`  in  DW  store data.
- `stall`  out  1  core must hold its PC and store this cycle.
- `rd_adr`  in  AW  core load address, used for forwarding lookup.
- `fwd_hit`  out  1  `rd_adr` matches a buffered entry.
- `fwd_data`  out  DW  data of the youngest matching entry.
- `m_valid`  out  1  head entry presented to memory.
- `m_adr`  out  AW  head address.
- `m_data`  out  DW  head data.
- `m_ready`  in  1  memory accepts the head this cycle.
- `count`  out  $clog2(DEPTH+1)  number of occupied entries.
- `empty`  out  1  `count == 0`.

## Operation
- State: `DEPTH` entries of {adr, data}, a per-entry valid bit, head and tail pointers of $clog2(DEPTH) bits, and `count`. Pointers wrap from DEPTH-1 to 0.
- Push: on a rising edge with `mem_write & !full`, write {`data_adr`, `write_data`} at the tail, set its valid bit, and increment the tail.
- Full means `count == DEPTH`.
- `stall = mem_write & full`. This is combinational and independent of `m_ready`. There is no same-cycle pop-then-push into a full buffer.
- Pop: on a rising edge with `m_valid & m_ready`, clear the head valid bit and increment the head.
- Push and pop in the same cycle (buffer not full): both take effect and `count` is unchanged.
- `count` increments on push only, decrements on pop only, and never exceeds `DEPTH` or goes below 0.
- `m_valid = !empty`.
  - `m_adr` and `m_data` show the head entry while valid.
  - Both are 0 when `!m_valid`.
  - Both hold stable while `m_valid & !m_ready`.
- Drain order is strictly FIFO. There is no coalescing of stores to the same address; each accepted store reaches memory exactly once.
- Forwarding is combinational on the current registered state.
  - Compare `rd_adr[AW-1:2]` against `adr[AW-1:2]` of every valid entry; the low two bits are ignored (word granularity).
  - `fwd_hit` is 1 if any entry matches.
  - `fwd_data` is the data of the match nearest the tail (youngest), or 0 when there is no hit.
  - The head entry being popped this cycle still forwards this cycle.
  - A store being pushed this cycle is not visible until the next cycle. The core tolerates this because loads read the memory or buffer after the store's edge.
- Stored addresses keep all AW bits; only the forwarding comparison masks bits [1:0].

## Timing
- Reset (`reset == 0`, asynchronous): head, tail and `count` go to 0, all valid bits clear, `m_valid` = 0, `m_adr`/`m_data` = 0, `fwd_hit` = 0, `fwd_data` = 0, `empty` = 1. `stall` follows `mem_write & full` and is therefore 0.
- Reset deassertion is synchronised externally. The first push can occur at the first rising edge after `reset` goes high.
- Store accepted at edge N gives `m_valid` = 1 from edge N onward (visible in cycle N+1) when the buffer was empty. Minimum store-to-memory latency is 1 cycle.
- Throughput is one push and one pop per cycle.
- Reset mid-operation discards all buffered stores. No partial drain is guaranteed.
- `stall`, `fwd_hit` and `fwd_data` are combinational. `m_valid`, `m_adr`, `m_data`, `count` and `empty` come from registers only.

## Test plan
- Reset, then `mem_write`=1 with `data_adr`=80 and `write_data`=7 for one cycle, `m_ready`=1 → next cycle `m_valid`=1, `m_adr`=80, `m_data`=7. One cycle later `m_valid`=0 and `count`=0.
- With `m_ready`=0, push 4 stores (adr 0,4,8,12; data 1,2,3,4). A 5th `mem_write` gives `stall`=1 and `count`=4. Raise `m_ready` → drain order 1,2,3,4 and `stall` drops the cycle after the first pop.
- With `m_ready`=0, push adr 84 data 4, then adr 84 data 9. `rd_adr`=86 gives `fwd_hit`=1 and `fwd_data`=9. `rd_adr`=88 gives `fwd_hit`=0 and `fwd_data`=0.
- With `count`=2, apply `mem_write` and `m_ready` in the same cycle → `count` stays 2 and the new entry lands after the existing tail. Continue for 10 cycles to cover pointer wrap with no loss or reorder.
- Assert `reset`=0 asynchronously mid-cycle with 3 entries buffered and `m_ready`=0 → `m_valid`, `count` and `fwd_hit` go to 0 immediately, before the next edge. Nothing is drained after release.
- Hold `m_ready`=0 for 5 cycles with one entry buffered (adr 80 data 4) → `m_adr`=80 and `m_data`=4 stay stable every cycle.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// In-order store buffer between the core store port and a valid/ready memory write port.
// One push and one pop per cycle; forwards the youngest matching word to core loads.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_write,
  input  logic [AW-1:0] data_adr,
  input  logic [DW-1:0] write_data,
  output logic          stall,
  input  logic [AW-1:0] rd_adr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic          m_valid,
  output logic [AW-1:0] m_adr,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [AW-1:0]    adr_q  [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    idx;
  logic             full;
  logic             push;
  logic             pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign m_valid = ~empty;
  assign stall   = mem_write & full;
  assign push    = mem_write & ~full;
  assign pop     = m_valid & m_ready;
  assign m_adr   = m_valid ? adr_q[head]  : '0;
  assign m_data  = m_valid ? data_q[head] : '0;

  // head == tail with both push and pop cannot happen: that requires empty (no pop) or full (no push)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        adr_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        vld_q[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (push) begin
        adr_q[tail]  <= data_adr;
        data_q[tail] <= write_data;
        vld_q[tail]  <= 1'b1;
        tail         <= tail + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (vld_q[idx] && (adr_q[idx][AW-1:2] == rd_adr[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized and directed bench for dmem_store_buffer against a queue-based reference model.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } st_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] data_adr = '0;
  logic [31:0] write_data = '0;
  logic        stall;
  logic [31:0] rd_adr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        m_valid;
  logic [31:0] m_adr;
  logic [31:0] m_data;
  logic        m_ready = 1'b0;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;
  st_t q[$];

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .stall(stall), .rd_adr(rd_adr), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .m_valid(m_valid), .m_adr(m_adr), .m_data(m_data),
    .m_ready(m_ready), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every output with what the queue model says for the current inputs
  task automatic check_model();
    logic        hit;
    logic [31:0] fd;
    hit = 1'b0;
    fd  = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].adr[31:2] == rd_adr[31:2]) begin
        hit = 1'b1;
        fd  = q[i].data;
        break;
      end
    end
    chk("count",   64'(count),   64'(q.size()));
    chk("empty",   64'(empty),   64'(q.size() == 0));
    chk("m_valid", 64'(m_valid), 64'(q.size() != 0));
    chk("m_adr",   64'(m_adr),   q.size() != 0 ? 64'(q[0].adr)  : 64'd0);
    chk("m_data",  64'(m_data),  q.size() != 0 ? 64'(q[0].data) : 64'd0);
    chk("stall",   64'(stall),   64'(mem_write && q.size() == DEPTH));
    chk("fwd_hit", 64'(fwd_hit), 64'(hit));
    chk("fwd_data",64'(fwd_data),64'(fd));
  endtask

  // Apply inputs for one cycle, check, then advance the model at the edge
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                      input logic rdy, input logic [31:0] ra);
    bit do_push, do_pop;
    @(negedge clk);
    mem_write = mw; data_adr = a; write_data = d; m_ready = rdy; rd_adr = ra;
    #1;
    check_model();
    do_push = mw && (q.size() < DEPTH);
    do_pop  = (q.size() != 0) && rdy;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{adr: a, data: d});
  endtask

  task automatic idle_drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 0, 0, 1'b1, 0);
  endtask

  initial begin
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_count",   64'(count),   64'd0);
    chk("rst_empty",   64'(empty),   64'd1);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single store reaches memory next cycle, then buffer empties
    step(1'b1, 80, 7, 1'b1, 0);
    #1;
    chk("t1_m_valid", 64'(m_valid), 64'd1);
    chk("t1_m_adr",   64'(m_adr),   64'd80);
    chk("t1_m_data",  64'(m_data),  64'd7);
    step(1'b0, 0, 0, 1'b1, 0);
    #1;
    chk("t1_m_valid_after", 64'(m_valid), 64'd0);
    chk("t1_count_after",   64'(count),   64'd0);

    // Fill to full, stall, then drain in order
    for (int i = 0; i < 4; i++) step(1'b1, 32'(4 * i), 32'(i + 1), 1'b0, 0);
    step(1'b1, 16, 5, 1'b0, 0);
    #1;
    chk("t2_stall", 64'(stall), 64'd1);
    chk("t2_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_drain_order", 64'(m_data), 64'(i + 1));
      step(i == 0, 16, 5, 1'b1, 0);
    end
    idle_drain();

    // Youngest of two same-word stores forwards
    step(1'b1, 84, 4, 1'b0, 0);
    step(1'b1, 84, 9, 1'b0, 86);
    step(1'b0, 0, 0, 1'b0, 86);
    chk("t3_fwd_hit",  64'(fwd_hit),  64'd1);
    chk("t3_fwd_data", 64'(fwd_data), 64'd9);
    step(1'b0, 0, 0, 1'b0, 88);
    chk("t3_miss_hit",  64'(fwd_hit),  64'd0);
    chk("t3_miss_data", 64'(fwd_data), 64'd0);
    idle_drain();

    // Steady push+pop at count 2 across pointer wrap
    step(1'b1, 200, 100, 1'b0, 0);
    step(1'b1, 204, 101, 1'b0, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'(208 + 4 * i), 32'(102 + i), 1'b1, 32'(200 + 4 * i));
    #1;
    chk("t4_count", 64'(count), 64'd2);
    idle_drain();

    // Asynchronous reset mid-cycle discards buffered stores
    for (int i = 0; i < 3; i++) step(1'b1, 32'(300 + 4 * i), 32'(50 + i), 1'b0, 0);
    @(negedge clk);
    mem_write = 1'b0; m_ready = 1'b0; rd_adr = 304;
    #1;
    chk("t5_pre_hit", 64'(fwd_hit), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_m_valid", 64'(m_valid), 64'd0);
    chk("t5_count",   64'(count),   64'd0);
    chk("t5_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("t5_m_adr",   64'(m_adr),   64'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 304);

    // Head holds stable under backpressure
    step(1'b1, 80, 4, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 0, 0, 1'b0, 0);
      chk("t6_m_adr",  64'(m_adr),  64'd80);
      chk("t6_m_data", 64'(m_data), 64'd4);
    end
    idle_drain();

    // Random traffic over a small address window so forwarding hits often
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, ra;
      a  = 32'(64 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3));
      ra = 32'(64 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 3) != 0), ra);
    end
    idle_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
